// File: rtl/matmul_pkg.sv
// Shared types and constants for the sequential matrix-multiply controller.
package matmul_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_A,
        CAP_A,
        ADDR_B,
        CAP_B,
        MAC,
        ADDR_C,
        CAP_C,
        WRITE,
        NEXT,
        DONE
    } state_t;

    localparam logic [1:0] MSEL_A = 2'd0;
    localparam logic [1:0] MSEL_B = 2'd1;
    localparam logic [1:0] MSEL_C = 2'd2;

    // Smallest accumulator that holds N signed products plus the C operand.
    function automatic int acc_width(input int n, input int data_w);
        return 2 * data_w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// Operand extension, multiply-accumulate, and result clamping with fit detection.
module matmul_mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + 2,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              signed_mode,
    input  logic              mac_en,
    input  logic              first,
    input  logic              add_c,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] product;
    logic             fits;

    function automatic logic [ACC_W-1:0] extend(input logic [DATA_W-1:0] x, input logic s);
        return s ? {{(ACC_W-DATA_W){x[DATA_W-1]}}, x} : {{(ACC_W-DATA_W){1'b0}}, x};
    endfunction

    assign product = extend(a, signed_mode) * extend(b, signed_mode);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (mac_en) begin
            acc <= first ? product : acc + product;
        end else if (add_c) begin
            acc <= acc + extend(c, signed_mode);
        end
    end

    // A signed value fits when all bits from the result sign bit upward agree.
    assign fits = signed_mode ? ((&acc[ACC_W-1:DATA_W-1]) || (~|acc[ACC_W-1:DATA_W-1]))
                              : (~|acc[ACC_W-1:DATA_W]);
    assign overflow = ~fits;

    always_comb begin
        result = acc[DATA_W-1:0];
        if (SAT != 0 && !fits) begin
            if (signed_mode) begin
                result = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                result = '1;
            end
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl_p.sv
// Sequential NxN matrix-multiply controller driving one shared matrix memory port.
module matmul_seq_ctrl_p
    import matmul_pkg::*;
#(
    parameter int N      = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = acc_width(N, DATA_W),
    parameter int SAT    = 1,
    parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_mode,
    input  logic              acc_mode,
    input  logic [DATA_W-1:0] read_data,
    output logic              done,
    output logic              busy,
    output logic              write_enable,
    output logic [1:0]        matrix_select,
    output logic [IDX_W-1:0]  row,
    output logic [IDX_W-1:0]  col,
    output logic [DATA_W-1:0] write_data,
    output logic              overflow
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t            state, next_state;
    logic [IDX_W-1:0]  i, j, k;
    logic              signed_l, acc_l;
    logic [DATA_W-1:0] a_reg, b_reg;
    logic [DATA_W-1:0] mac_result;
    logic              mac_ovf;
    logic              accept;

    // A start seen during the done pulse is ignored even though the state is already IDLE.
    assign accept = (state == IDLE) && start && !done;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ADDR_A;
            ADDR_A:  next_state = CAP_A;
            CAP_A:   next_state = ADDR_B;
            ADDR_B:  next_state = CAP_B;
            CAP_B:   next_state = MAC;
            MAC:     next_state = (k == LAST) ? (acc_l ? ADDR_C : WRITE) : ADDR_A;
            ADDR_C:  next_state = CAP_C;
            CAP_C:   next_state = WRITE;
            WRITE:   next_state = (i == LAST && j == LAST) ? DONE : NEXT;
            NEXT:    next_state = ADDR_A;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i <= '0; j <= '0; k <= '0;
            signed_l <= 1'b0; acc_l <= 1'b0;
            a_reg <= '0; b_reg <= '0;
            matrix_select <= MSEL_A; row <= '0; col <= '0;
            done <= 1'b0; busy <= 1'b0; overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        signed_l <= signed_mode;
                        acc_l    <= acc_mode;
                        i <= '0; j <= '0; k <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ADDR_A: begin
                    matrix_select <= MSEL_A; row <= i; col <= k;
                end
                CAP_A: a_reg <= read_data;
                ADDR_B: begin
                    matrix_select <= MSEL_B; row <= k; col <= j;
                end
                CAP_B: b_reg <= read_data;
                MAC: begin
                    // Without a C fetch the write address is set up here so WRITE drives it directly.
                    if (k == LAST) begin
                        if (!acc_l) begin
                            matrix_select <= MSEL_C; row <= i; col <= j;
                        end
                    end else begin
                        k <= k + IDX_W'(1);
                    end
                end
                ADDR_C: begin
                    matrix_select <= MSEL_C; row <= i; col <= j;
                end
                WRITE: overflow <= overflow | mac_ovf;
                NEXT: begin
                    k <= '0;
                    if (j == LAST) begin
                        j <= '0;
                        i <= i + IDX_W'(1);
                    end else begin
                        j <= j + IDX_W'(1);
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign write_enable = (state == WRITE);
    assign write_data   = write_enable ? mac_result : '0;

    matmul_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SAT    (SAT)
    ) u_mac (
        .clk         (clk),
        .reset       (reset),
        .signed_mode (signed_l),
        .mac_en      (state == MAC),
        .first       (k == '0),
        .add_c       (state == CAP_C),
        .a           (a_reg),
        .b           (b_reg),
        .c           (read_data),
        .result      (mac_result),
        .overflow    (mac_ovf)
    );

endmodule

// File: tb/tb_matmul_seq_ctrl_p.sv
// Scoreboard bench: three controller instances (N=3 saturating, N=3 truncating, N=2) share one memory model.
module tb_matmul_seq_ctrl_p;

    typedef struct {
        int dut;
        int r;
        int c;
        int d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_v [3];
    logic       signed_mode = 1'b0;
    logic       acc_mode = 1'b0;
    logic       done_v [3];
    logic       busy_v [3];
    logic       we_v [3];
    logic       ovf_v [3];
    logic [1:0] sel_v [3];
    logic [1:0] row_v [3];
    logic [1:0] col_v [3];
    logic [7:0] wd_v [3];
    logic [7:0] rd_v [3];
    logic [7:0] mem [4][3][3];

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NN = (g == 2) ? 2 : 3;
        localparam int SS = (g == 1) ? 0 : 1;
        localparam int IW = (NN > 1) ? $clog2(NN) : 1;
        logic [IW-1:0] r, c;

        matmul_seq_ctrl_p #(.N(NN), .DATA_W(8), .SAT(SS)) u_dut (
            .clk           (clk),
            .reset         (reset),
            .start         (start_v[g]),
            .signed_mode   (signed_mode),
            .acc_mode      (acc_mode),
            .read_data     (rd_v[g]),
            .done          (done_v[g]),
            .busy          (busy_v[g]),
            .write_enable  (we_v[g]),
            .matrix_select (sel_v[g]),
            .row           (r),
            .col           (c),
            .write_data    (wd_v[g]),
            .overflow      (ovf_v[g])
        );

        assign row_v[g] = 2'(r);
        assign col_v[g] = 2'(c);
        assign rd_v[g]  = mem[sel_v[g]][row_v[g]][col_v[g]];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic longint ext(input logic [7:0] x, input bit sm);
        return sm ? longint'($signed(x)) : longint'(x);
    endfunction

    // Reference: C = A*B (+C), each element clamped or truncated to 8 bits, pushed row-major.
    task automatic buildExpected(input int dut, input bit sm, input bit am, output bit exp_ovf);
        int n;
        bit sat;
        longint s;
        bit fits;
        logic [7:0] dd;
        exp_t e;
        n = (dut == 2) ? 2 : 3;
        sat = (dut != 1);
        exp_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = am ? ext(mem[2][i][j], sm) : 0;
                for (int k = 0; k < n; k++) s += ext(mem[0][i][k], sm) * ext(mem[1][k][j], sm);
                fits = sm ? (s >= -128 && s <= 127) : (s >= 0 && s <= 255);
                dd = s[7:0];
                if (!fits) begin
                    exp_ovf = 1'b1;
                    if (sat) dd = sm ? ((s < 0) ? 8'h80 : 8'h7F) : 8'hFF;
                end
                e.dut = dut; e.r = i; e.c = j; e.d = int'(dd);
                q.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input int dut, input bit sm, input bit am, input bit extra_start);
        int n, cnt;
        bit got, exp_ovf;
        n = (dut == 2) ? 2 : 3;
        buildExpected(dut, sm, am, exp_ovf);
        @(negedge clk);
        signed_mode = sm;
        acc_mode = am;
        start_v[dut] = 1'b1;
        cnt = 0;
        got = 1'b0;
        while (cnt < 3000 && !got) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                start_v[dut] = 1'b0;
                checkOutput("busy_after_start", int'(busy_v[dut]), 1);
            end
            // Mode inputs must be latched, so flipping them mid-run changes nothing.
            if (cnt == 2) begin
                signed_mode = ~sm;
                acc_mode = ~am;
            end
            if (extra_start && cnt == 20) start_v[dut] = 1'b1;
            if (extra_start && cnt == 21) start_v[dut] = 1'b0;
            if (done_v[dut]) got = 1'b1;
        end
        checkOutput("done_seen", int'(got), 1);
        checkOutput("latency", cnt - 1, n * n * (5 * n + (am ? 4 : 2)));
        checkOutput("busy_at_done", int'(busy_v[dut]), 0);
        checkOutput("overflow", int'(ovf_v[dut]), int'(exp_ovf));
        checkOutput("writes_pending", q.size(), 0);
        q.delete();
        repeat (3) @(negedge clk);
        checkOutput("done_pulse_width", int'(done_v[dut]), 0);
        checkOutput("idle_after_run", int'(busy_v[dut]), 0);
        checkOutput("overflow_holds", int'(ovf_v[dut]), int'(exp_ovf));
    endtask

    task automatic resetMidRun();
        bit exp_ovf;
        buildExpected(0, 1'b0, 1'b0, exp_ovf);
        @(negedge clk);
        signed_mode = 1'b0;
        acc_mode = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        checkOutput("outputs_after_reset",
                    int'({done_v[0], busy_v[0], we_v[0], sel_v[0], row_v[0], col_v[0], wd_v[0], ovf_v[0]}), 0);
        repeat (200) @(negedge clk);
        checkOutput("no_run_after_reset", int'(busy_v[0]), 0);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (we_v[d] === 1'b1) begin
                if (q.size() == 0) begin
                    checkOutput("unexpected_write", d, -1);
                end else begin
                    mon_e = q.pop_front();
                    checkOutput("write_dut", d, mon_e.dut);
                    checkOutput("write_row", int'(row_v[d]), mon_e.r);
                    checkOutput("write_col", int'(col_v[d]), mon_e.c);
                    checkOutput("write_data", int'(wd_v[d]), mon_e.d);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) mem[s][r][c] = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++)
            checkOutput("reset_state",
                        int'({done_v[d], busy_v[d], we_v[d], sel_v[d], row_v[d], col_v[d], wd_v[d], ovf_v[d]}), 0);

        $display("[TB] identity times 1..9, with a stray start mid-run");
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                mem[0][r][c] = (r == c) ? 8'd1 : 8'd0;
                mem[1][r][c] = 8'(3 * r + c + 1);
                mem[2][r][c] = 8'd5;
            end
        applyStimulus(0, 1'b0, 1'b0, 1'b1);

        $display("[TB] accumulate mode, C preloaded with 5");
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) mem[1][r][c] = 8'd1;
        applyStimulus(0, 1'b0, 1'b1, 1'b0);

        $display("[TB] signed -1 times 2");
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                mem[0][r][c] = 8'hFF;
                mem[1][r][c] = 8'd2;
            end
        applyStimulus(0, 1'b1, 1'b0, 1'b0);

        $display("[TB] unsigned 200s, saturating then truncating");
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                mem[0][r][c] = 8'd200;
                mem[1][r][c] = 8'd200;
            end
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0);

        $display("[TB] N=2 instance");
        mem[0][0][0] = 8'd1; mem[0][0][1] = 8'd2; mem[0][1][0] = 8'd3; mem[0][1][1] = 8'd4;
        mem[1][0][0] = 8'd5; mem[1][0][1] = 8'd6; mem[1][1][0] = 8'd7; mem[1][1][1] = 8'd8;
        applyStimulus(2, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset in the middle of a run, then a clean run");
        resetMidRun();
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        $display("[TB] randomized runs");
        for (int t = 0; t < 8; t++) begin
            int lim;
            lim = (t % 2 == 0) ? 15 : 255;
            for (int s = 0; s < 3; s++)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) mem[s][r][c] = 8'($urandom_range(0, lim));
            applyStimulus(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
